// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arbiter
//  Description : Shares the data-memory port between the pipeline memory
//                stage (port A) and a debug/loader requester (port B).
//                Port A normally wins. A saturating wait counter forces B
//                ahead after MAX_WAIT contended cycles. B requests are
//                range- and alignment-checked before reaching memory.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
    parameter logic [31:0] DMEM_BASE = 32'h0010_0000,
    parameter int unsigned DMEM_SIZE = 32768,
    parameter int unsigned MAX_WAIT  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    // port A: pipeline memory-access stage
    input  logic [31:0] a_addr,
    input  logic [31:0] a_wdata,
    input  logic [1:0]  a_read_status,
    input  logic [1:0]  a_write_status,
    input  logic        a_load_signed,
    output logic        a_stall,
    output logic        a_rvalid,
    output logic [31:0] a_rdata,
    // port B: debug / loader
    input  logic        b_req,
    input  logic        b_write,
    input  logic [1:0]  b_size,
    input  logic [31:0] b_addr,
    input  logic [31:0] b_wdata,
    output logic        b_gnt,
    output logic        b_rvalid,
    output logic        b_err,
    output logic [31:0] b_rdata,
    // memory side (aligner + data RAM)
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [1:0]  m_read_status,
    output logic [1:0]  m_write_status,
    output logic        m_load_signed,
    input  logic [31:0] m_rdata
);

    localparam logic [1:0]  c_DM_NONE   = 2'd0;
    localparam logic [1:0]  c_DM_HALF   = 2'd2;
    localparam logic [1:0]  c_DM_WORD   = 2'd3;

    localparam logic [3:0]  c_MAX_WAIT  = MAX_WAIT[3:0];
    localparam logic [31:0] c_DMEM_SIZE = DMEM_SIZE[31:0];

    localparam logic [1:0]  c_OWN_NONE  = 2'd0;
    localparam logic [1:0]  c_OWN_A     = 2'd1;
    localparam logic [1:0]  c_OWN_B     = 2'd2;

    localparam logic [2:0]  c_RSP_NONE  = 3'd0;
    localparam logic [2:0]  c_RSP_A_RD  = 3'd1;
    localparam logic [2:0]  c_RSP_A_WR  = 3'd2;
    localparam logic [2:0]  c_RSP_B_RD  = 3'd3;
    localparam logic [2:0]  c_RSP_B_WR  = 3'd4;
    localparam logic [2:0]  c_RSP_B_ERR = 3'd5;

    logic [3:0]  r_wait_cnt;
    logic [2:0]  r_rsp;
    logic [2:0]  w_rsp_nxt;
    logic [1:0]  w_owner;
    logic        w_a_active;
    logic        w_force_b;
    logic [31:0] w_b_offset;
    logic        w_b_in_range;
    logic        w_b_aligned;
    logic        w_b_legal;

    assign w_a_active = (a_read_status != c_DM_NONE) || (a_write_status != c_DM_NONE);
    assign w_force_b  = b_req && (r_wait_cnt == c_MAX_WAIT);

    // Below-base addresses underflow to a huge offset, so one unsigned
    // compare also catches them; the explicit >= keeps intent obvious.
    assign w_b_offset   = b_addr - DMEM_BASE;
    assign w_b_in_range = (b_addr >= DMEM_BASE) && (w_b_offset < c_DMEM_SIZE);

    // Alignment rule per access size; DM_NONE is never a legal B size.
    always_comb begin
        w_b_aligned = 1'b1;
        case (b_size)
            c_DM_NONE: w_b_aligned = 1'b0;
            c_DM_HALF: w_b_aligned = (b_addr[0] == 1'b0);
            c_DM_WORD: w_b_aligned = (b_addr[1:0] == 2'b00);
            default:   w_b_aligned = 1'b1;
        endcase
    end

    assign w_b_legal = w_b_in_range && w_b_aligned;

    // Owner selection: forced B, else A, else B; nobody owns the port in reset.
    always_comb begin
        w_owner = c_OWN_NONE;
        if (!rst_n)
            w_owner = c_OWN_NONE;
        else if (w_force_b)
            w_owner = c_OWN_B;
        else if (w_a_active)
            w_owner = c_OWN_A;
        else if (b_req)
            w_owner = c_OWN_B;
    end

    assign b_gnt   = (w_owner == c_OWN_B);
    assign a_stall = w_a_active && (w_owner == c_OWN_B);

    // Memory drive: A passes straight through to keep pipeline timing.
    always_comb begin
        m_addr         = 32'd0;
        m_wdata        = 32'd0;
        m_read_status  = c_DM_NONE;
        m_write_status = c_DM_NONE;
        m_load_signed  = 1'b0;
        if (w_owner == c_OWN_A) begin
            m_addr         = a_addr;
            m_wdata        = a_wdata;
            m_read_status  = a_read_status;
            m_write_status = a_write_status;
            m_load_signed  = a_load_signed;
        end else if ((w_owner == c_OWN_B) && w_b_legal) begin
            m_addr  = b_addr;
            m_wdata = b_wdata;
            if (b_write)
                m_write_status = b_size;
            else
                m_read_status  = b_size;
        end
    end

    // Wait counter: counts B cycles lost to A, saturating; any B grant clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt <= 4'd0;
        end else if (w_owner == c_OWN_B) begin
            r_wait_cnt <= 4'd0;
        end else if (b_req && (w_owner == c_OWN_A) && (r_wait_cnt < c_MAX_WAIT)) begin
            r_wait_cnt <= r_wait_cnt + 4'd1;
        end
    end

    // Response state register, reloaded every cycle from this cycle's owner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_rsp <= c_RSP_NONE;
        else
            r_rsp <= w_rsp_nxt;
    end

    // Next response state and response outputs decoded from the current state.
    always_comb begin
        w_rsp_nxt = c_RSP_NONE;
        a_rvalid  = 1'b0;
        a_rdata   = 32'd0;
        b_rvalid  = 1'b0;
        b_err     = 1'b0;
        b_rdata   = 32'd0;

        if (w_owner == c_OWN_A)
            w_rsp_nxt = (a_read_status != c_DM_NONE) ? c_RSP_A_RD : c_RSP_A_WR;
        else if (w_owner == c_OWN_B)
            w_rsp_nxt = !w_b_legal ? c_RSP_B_ERR : (b_write ? c_RSP_B_WR : c_RSP_B_RD);

        case (r_rsp)
            c_RSP_A_RD: begin
                a_rvalid = 1'b1;
                a_rdata  = m_rdata;
            end
            c_RSP_A_WR: a_rvalid = 1'b1;
            c_RSP_B_RD: begin
                b_rvalid = 1'b1;
                b_rdata  = m_rdata;
            end
            c_RSP_B_WR: b_rvalid = 1'b1;
            c_RSP_B_ERR: begin
                b_rvalid = 1'b1;
                b_err    = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_arbiter
//  Description : Self-checking bench for dmem_arbiter: directed scenarios
//                followed by constrained-random traffic, all compared against
//                a behavioural reference model and a small memory model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    localparam logic [31:0] c_BASE = 32'h0010_0000;
    localparam int          c_SIZE = 32768;
    localparam int          c_MW   = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] a_addr = '0, a_wdata = '0;
    logic [1:0]  a_read_status = '0, a_write_status = '0;
    logic        a_load_signed = 1'b0;
    logic        a_stall, a_rvalid;
    logic [31:0] a_rdata;
    logic        b_req = 1'b0, b_write = 1'b0;
    logic [1:0]  b_size = 2'd3;
    logic [31:0] b_addr = '0, b_wdata = '0;
    logic        b_gnt, b_rvalid, b_err;
    logic [31:0] b_rdata;
    logic [31:0] m_addr, m_wdata;
    logic [1:0]  m_read_status, m_write_status;
    logic        m_load_signed;
    logic [31:0] m_rdata = '0;

    dmem_arbiter #(
        .DMEM_BASE(c_BASE),
        .DMEM_SIZE(c_SIZE),
        .MAX_WAIT (c_MW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .a_addr        (a_addr),
        .a_wdata       (a_wdata),
        .a_read_status (a_read_status),
        .a_write_status(a_write_status),
        .a_load_signed (a_load_signed),
        .a_stall       (a_stall),
        .a_rvalid      (a_rvalid),
        .a_rdata       (a_rdata),
        .b_req         (b_req),
        .b_write       (b_write),
        .b_size        (b_size),
        .b_addr        (b_addr),
        .b_wdata       (b_wdata),
        .b_gnt         (b_gnt),
        .b_rvalid      (b_rvalid),
        .b_err         (b_err),
        .b_rdata       (b_rdata),
        .m_addr        (m_addr),
        .m_wdata       (m_wdata),
        .m_read_status (m_read_status),
        .m_write_status(m_write_status),
        .m_load_signed (m_load_signed),
        .m_rdata       (m_rdata)
    );

    always #5 clk = ~clk;

    // Word-granular memory model standing in for aligner + RAM.
    logic [31:0] ram [int unsigned];

    function automatic logic [31:0] ram_rd(input logic [31:0] addr);
        if (ram.exists(addr >> 2)) return ram[addr >> 2];
        return addr ^ 32'hA5A5_0000;
    endfunction

    always @(posedge clk) begin
        if (m_write_status != 2'd0) ram[m_addr >> 2] = m_wdata;
        if (m_read_status != 2'd0) m_rdata <= ram_rd(m_addr);
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Reference model state: arbitration debt and the response due next cycle.
    int          mdl_wait = 0;
    bit          exp_av = 0, exp_bv = 0, exp_be = 0;
    logic [31:0] exp_ad = '0, exp_bd = '0;
    bit          obs_gnt, obs_stall;

    function automatic bit b_legal(input logic [31:0] addr, input logic [1:0] size);
        longint a = longint'(addr);
        bit ok = (a >= longint'(c_BASE)) && (a < longint'(c_BASE) + c_SIZE);
        if (size == 2'd0) ok = 0;
        if (size == 2'd2 && (addr % 2) != 0) ok = 0;
        if (size == 2'd3 && (addr % 4) != 0) ok = 0;
        return ok;
    endfunction

    task automatic model_reset();
        mdl_wait = 0;
        exp_av = 0; exp_bv = 0; exp_be = 0;
        exp_ad = '0; exp_bd = '0;
    endtask

    // One clock cycle: inputs already driven after a negedge; checks all
    // outputs against the model, advances the model, returns at next negedge.
    task automatic cycle();
        bit a_act, legal;
        int own;   // 0 none, 1 A, 2 B
        logic [31:0] ea, ew;
        logic [1:0]  er, ewr;
        bit          els;
        #1;
        a_act = (a_read_status != 0) || (a_write_status != 0);
        legal = b_legal(b_addr, b_size);
        if (b_req && mdl_wait >= c_MW) own = 2;
        else if (a_act)                own = 1;
        else if (b_req)                own = 2;
        else                           own = 0;
        ea = '0; ew = '0; er = 0; ewr = 0; els = 0;
        if (own == 1) begin
            ea = a_addr; ew = a_wdata; er = a_read_status; ewr = a_write_status; els = a_load_signed;
        end else if (own == 2 && legal) begin
            ea = b_addr; ew = b_wdata;
            if (b_write) ewr = b_size; else er = b_size;
        end
        check("b_gnt",     32'(b_gnt),          32'(own == 2));
        check("a_stall",   32'(a_stall),        32'(a_act && own == 2));
        check("m_addr",    m_addr,              ea);
        check("m_wdata",   m_wdata,             ew);
        check("m_rd_stat", 32'(m_read_status),  32'(er));
        check("m_wr_stat", 32'(m_write_status), 32'(ewr));
        check("m_lsigned", 32'(m_load_signed),  32'(els));
        check("a_rvalid",  32'(a_rvalid),       32'(exp_av));
        check("a_rdata",   a_rdata,             exp_ad);
        check("b_rvalid",  32'(b_rvalid),       32'(exp_bv));
        check("b_err",     32'(b_err),          32'(exp_be));
        check("b_rdata",   b_rdata,             exp_bd);
        obs_gnt = b_gnt;
        obs_stall = a_stall;

        exp_av = 0; exp_bv = 0; exp_be = 0; exp_ad = '0; exp_bd = '0;
        if (own == 1) begin
            exp_av = 1;
            if (a_read_status != 0) exp_ad = ram_rd(a_addr);
        end else if (own == 2) begin
            exp_bv = 1;
            if (!legal) exp_be = 1;
            else if (!b_write) exp_bd = ram_rd(b_addr);
        end
        if (own == 2) mdl_wait = 0;
        else if (own == 1 && b_req && mdl_wait < c_MW) mdl_wait++;

        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic a_idle();
        a_read_status = 0; a_write_status = 0; a_addr = '0; a_wdata = '0; a_load_signed = 0;
    endtask

    task automatic a_load(input logic [31:0] addr);
        a_read_status = 2'd3; a_write_status = 0; a_addr = addr; a_load_signed = 0;
    endtask

    task automatic b_set(input bit wr, input logic [1:0] sz, input logic [31:0] addr, input logic [31:0] wd);
        b_req = 1; b_write = wr; b_size = sz; b_addr = addr; b_wdata = wd;
    endtask

    logic [31:0] ill_addr [3];
    logic [1:0]  ill_size [3];
    logic [4:0]  gnt_hist, stall_hist;
    bit          a_hold;

    initial begin
        ill_addr[0] = 32'h0010_0001; ill_size[0] = 2'd2;
        ill_addr[1] = 32'h0010_8000; ill_size[1] = 2'd3;
        ill_addr[2] = 32'h000F_FFFC; ill_size[2] = 2'd3;

        // Reset and release
        rst_n = 0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check("rst_a_rvalid", 32'(a_rvalid), 32'd0);
        check("rst_b_gnt",    32'(b_gnt),    32'd0);
        @(negedge clk);
        rst_n = 1;

        // Reset in the cycle after an A load issue: response dropped
        a_load(c_BASE);
        cycle();
        rst_n = 0;
        #1;
        check("rstmid_a_rvalid", 32'(a_rvalid),      32'd0);
        check("rstmid_a_rdata",  a_rdata,            32'd0);
        check("rstmid_m_addr",   m_addr,             32'd0);
        check("rstmid_m_rstat",  32'(m_read_status), 32'd0);
        check("rstmid_a_stall",  32'(a_stall),       32'd0);
        @(negedge clk);
        a_idle();
        model_reset();
        rst_n = 1;
        cycle();

        // A alone: word load with a known memory word
        ram[(c_BASE + 32'h4) >> 2] = 32'hDEAD_BEEF;
        a_load(c_BASE + 32'h4);
        #1;
        check("A_m_addr", m_addr, 32'h0010_0004);
        cycle();
        a_idle();
        #1;
        check("A_rvalid", 32'(a_rvalid), 32'd1);
        check("A_rdata",  a_rdata,       32'hDEAD_BEEF);
        cycle();

        // B alone: store then load back
        b_set(1, 2'd3, 32'h0010_0010, 32'h1234_5678);
        #1;
        check("B_st_gnt", 32'(b_gnt), 32'd1);
        cycle();
        b_req = 0;
        #1;
        check("B_st_rvalid", 32'(b_rvalid), 32'd1);
        check("B_st_err",    32'(b_err),    32'd0);
        b_set(0, 2'd3, 32'h0010_0010, 32'h0);
        cycle();
        b_req = 0;
        #1;
        check("B_ld_rvalid", 32'(b_rvalid), 32'd1);
        check("B_ld_rdata",  b_rdata,       32'h1234_5678);
        check("B_ld_err",    32'(b_err),    32'd0);
        cycle();

        // Starvation: A continuously active, B forced in on 5th cycle, twice
        for (int rep = 0; rep < 2; rep++) begin
            a_load(c_BASE + 32'h8);
            b_set(0, 2'd3, c_BASE + 32'h20 + 32'(rep * 4), 32'h0);
            gnt_hist = '0; stall_hist = '0;
            for (int i = 0; i < 5; i++) begin
                cycle();
                gnt_hist[i] = obs_gnt;
                stall_hist[i] = obs_stall;
                if (obs_gnt) b_req = 0;
            end
            check("starve_gnt",   32'(gnt_hist),   32'b10000);
            check("starve_stall", 32'(stall_hist), 32'b10000);
        end
        a_idle();
        b_req = 0;
        cycle();

        // Illegal B requests
        for (int k = 0; k < 3; k++) begin
            b_set(0, ill_size[k], ill_addr[k], 32'h0);
            #1;
            check("ill_gnt",   32'(b_gnt),          32'd1);
            check("ill_rstat", 32'(m_read_status),  32'd0);
            check("ill_wstat", 32'(m_write_status), 32'd0);
            cycle();
            b_req = 0;
            #1;
            check("ill_rvalid", 32'(b_rvalid), 32'd1);
            check("ill_err",    32'(b_err),    32'd1);
        end
        cycle();

        // Simultaneous A and B with no wait debt: A first, then B
        a_load(c_BASE + 32'hC);
        b_set(0, 2'd3, c_BASE + 32'h40, 32'h0);
        #1;
        check("sim_a_stall", 32'(a_stall), 32'd0);
        check("sim_b_gnt",   32'(b_gnt),   32'd0);
        cycle();
        a_idle();
        #1;
        check("sim_b_gnt2", 32'(b_gnt), 32'd1);
        cycle();
        b_req = 0;
        #1;
        check("sim_b_rvalid", 32'(b_rvalid), 32'd1);
        cycle();

        // Constrained-random traffic
        a_hold = 0;
        for (int n = 0; n < 600; n++) begin
            if (!a_hold) begin
                a_idle();
                case ($urandom_range(0, 3))
                    1, 3: begin
                        a_read_status = 2'($urandom_range(1, 3));
                        a_addr = c_BASE + ($urandom_range(0, c_SIZE - 1) & ~32'h3);
                        a_load_signed = 1'($urandom);
                    end
                    2: begin
                        a_write_status = 2'($urandom_range(1, 3));
                        a_addr = c_BASE + ($urandom_range(0, c_SIZE - 1) & ~32'h3);
                        a_wdata = $urandom;
                    end
                    default: ;
                endcase
            end
            if (!b_req && $urandom_range(0, 2) == 0) begin
                case ($urandom_range(0, 4))
                    0:       b_addr = c_BASE - 32'($urandom_range(1, 16));
                    1:       b_addr = c_BASE + c_SIZE - 32'($urandom_range(0, 4));
                    default: b_addr = c_BASE + $urandom_range(0, c_SIZE - 1);
                endcase
                b_size = 2'($urandom_range(1, 3));
                b_write = 1'($urandom);
                b_wdata = $urandom;
                b_req = 1;
            end
            cycle();
            a_hold = obs_stall;
            if (obs_gnt) b_req = 0;
        end
        a_idle();
        b_req = 0;
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    // Hard time bound so the run always terminates.
    initial begin
        #500000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
